fetch: RTL and testbench
========================

# fetch

Instruction fetch stage of the rv32 pipeline and the responder to the hazard unit's `bubble`/`stall` outputs. It generates the PC, issues reads to a synchronous instruction memory, buffers returned words and presents `{pc, ir}` to decode on a valid/ready stream. While a control transfer is unresolved it holds off fetching and flushes speculative words, then restarts from the redirect target supplied by execute.

## Interface
- `RESET_ADDR`, default `32'h0000_0000`: first PC after reset; bits [1:0] must be 0.
- `clk`  in  1  pipeline clock.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  load-use stall from hazard unit: freezes fetch.
- `bubble`  in  1  decode holds JAL/JALR/BRANCH: flush and wait for redirect.
- `redirect_valid`  in  1  resolved next PC from execute.
- `redirect_addr`  in  32  redirect target.
- `imem_en`  out  1  read strobe.
- `imem_addr`  out  32  word-aligned read address.
- `imem_rdata`  in  32  read data, valid the cycle after `imem_en`.
- `decode_tvalid`  out  1  output word valid.
- `decode_tready`  in  1  decode accepts.
- `decode_pc`  out  32  PC of output word.
- `decode_ir`  out  32  instruction of output word.
- `fault`  out  1  misaligned redirect (see Configuration).

## Operation
- Storage: PC register, output register (OUT), one-entry skid register (SKID), in-flight flag `pend` and kill flag `kill`.
- States: RUN (fetching sequentially), WAIT (transfer pending, no issue).
- Accept = `decode_tvalid & decode_tready & ~stall`; without it OUT holds and `decode_pc`/`decode_ir` stay stable.
- Issue in RUN when `~stall & ~bubble & ~redirect_valid` and SKID will be empty next cycle (SKID empty and not (`pend` and OUT held)). On issue: `imem_en`=1, `imem_addr`=PC, PC<=PC+4 (mod 2^32; `32'hFFFF_FFFC` wraps to 0), `pend`<=1.
- Return (`pend` & ~`kill`): word goes to OUT if OUT empty or accepted this cycle, else to SKID. On accept with SKID full, SKID moves to OUT. Order preserved.
- `bubble` (RUN): OUT, SKID invalidated; in-flight read marked `kill` and dropped; state<=WAIT. The word already in decode is untouched.
- `redirect_valid` (any state): flush as for bubble; PC<=target; state<=RUN; first issue next cycle. Redirect in the same cycle as bubble: redirect wins. Not-taken branches are still redirected (to pc+4) by execute.
- `stall` has priority over issue only; redirect and bubble act during stall.
- `stall` and `bubble` together: flush, enter WAIT.

## Timing
- Reset values: state=RUN, PC=`RESET_ADDR`, OUT/SKID/`pend`/`kill` cleared, `decode_tvalid`=0, `imem_en`=0, `fault`=0. Reset mid-operation discards everything, including in-flight reads.
- First issue: first cycle with `reset` low; `decode_tvalid` rises 2 cycles later (issue n, data n+1, OUT valid n+2).
- Redirect at cycle n: issue at n+1, `decode_tvalid` at n+3 with `decode_pc`=target.
- Steady state with `decode_tready`=1: one word per cycle, no gaps.
- Backpressure: at most OUT+SKID=2 words held; no words lost or duplicated.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: redirect with `redirect_addr[1:0]`!=0 does not update PC; flush occurs, state<=WAIT, `fault`=1 for exactly that one cycle after the redirect edge (registered).
- Not defined: `redirect_addr[1:0]` forced to 0; `fault` tied 0.

## Test plan
- Reset with `RESET_ADDR`=`32'h100`, `decode_tready`=1 -> `imem_addr` 0x100,0x104,0x108 on consecutive cycles; `decode_pc` 0x100 two cycles after reset release, then +4 per cycle.
- Hold `decode_tready`=0 for 5 cycles mid-stream -> `imem_en` stops after at most 2 extra words; release -> words resume in order, no PC gap or repeat.
- `stall`=1 for 3 cycles with `decode_tready`=1 -> no accept, no issue, outputs stable; continues from next PC afterwards.
- `bubble` at `decode_pc`=0x200, redirect 0x400 three cycles later -> no valid words in between; next `decode_pc`=0x400, word from 0x204 never appears.
- PC at `32'hFFFF_FFFC` -> next `imem_addr`=0x0.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 0x402 -> `fault` pulses 1 cycle, fetch stays idle until a valid redirect to 0x404, which fetches 0x404.

Source files
------------

// File: rtl/fetch.sv
// fetch: rv32 instruction fetch stage with PC generation, OUT/SKID buffering and redirect/bubble flushing.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirects raise fault and park fetch in WAIT.
`default_nettype none

module fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        bubble,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        decode_tvalid,
    input  logic        decode_tready,
    output logic [31:0] decode_pc,
    output logic [31:0] decode_ir,
    output logic        fault
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d, out_ir_q, out_ir_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d, skid_ir_q, skid_ir_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        fault_q, fault_d;

    logic        accept, flush, kill, ret, out_held, misalign, issue;
    logic [31:0] target;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = redirect_valid & (redirect_addr[1:0] != 2'b00);
    assign target   = redirect_addr;
`else
    assign misalign = 1'b0;
    assign target   = redirect_addr & 32'hFFFF_FFFC;
`endif

    assign accept   = out_valid_q & decode_tready & ~stall;
    assign out_held = out_valid_q & ~accept;
    assign flush    = bubble | redirect_valid;
    // A read returning in a flush cycle belongs to the abandoned path and is dropped.
    assign kill     = pend_q & flush;
    assign ret      = pend_q & ~kill;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RUN;
            pc_q         <= RESET_ADDR;
            out_valid_q  <= 1'b0;
            out_pc_q     <= 32'h0;
            out_ir_q     <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_ir_q    <= 32'h0;
            pend_q       <= 1'b0;
            pend_pc_q    <= 32'h0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_ir_q     <= out_ir_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_ir_q    <= skid_ir_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = misalign ? S_WAIT : S_RUN;
        end else if (bubble) begin
            state_d = S_WAIT;
        end
    end

    // Issue only when SKID is guaranteed to have room for the returning word.
    always_comb begin
        issue = (state_q == S_RUN) & ~reset & ~stall & ~bubble & ~redirect_valid
              & ~skid_valid_q & ~(pend_q & out_held);
    end

    assign imem_en       = issue;
    assign imem_addr     = pc_q;
    assign decode_tvalid = out_valid_q;
    assign decode_pc     = out_pc_q;
    assign decode_ir     = out_ir_q;
    assign fault         = fault_q;

    always_comb begin
        pc_d      = pc_q;
        pend_d    = issue;
        pend_pc_d = pend_pc_q;
        fault_d   = misalign;
        if (redirect_valid & ~misalign) begin
            pc_d = target;
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end
        if (issue) begin
            pend_pc_d = pc_q;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_ir_d     = out_ir_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_ir_d    = skid_ir_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (accept & skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_pc_d     = skid_pc_q;
            out_ir_d     = skid_ir_q;
            skid_valid_d = ret;
            skid_pc_d    = pend_pc_q;
            skid_ir_d    = imem_rdata;
        end else if (accept | ~out_valid_q) begin
            out_valid_d = ret;
            out_pc_d    = pend_pc_q;
            out_ir_d    = imem_rdata;
        end else if (ret) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = pend_pc_q;
            skid_ir_d    = imem_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
// tb_fetch: directed self-checking bench for fetch with an in-order stream checker on accepted words.
`default_nettype none

module tb_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        bubble = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        decode_tvalid;
    logic        decode_tready = 1'b1;
    logic [31:0] decode_pc;
    logic [31:0] decode_ir;
    logic        fault;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_acc = 0;
    int          n_issue = 0;
    logic [31:0] exp_pc = 32'h100;

    always #5 clk = ~clk;

    fetch #(.RESET_ADDR(32'h100)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .bubble         (bubble),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .decode_tvalid  (decode_tvalid),
        .decode_tready  (decode_tready),
        .decode_pc      (decode_pc),
        .decode_ir      (decode_ir),
        .fault          (fault)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    always @(posedge clk) imem_rdata <= imem_en ? memf(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every accepted word must be the next sequential PC of the current path.
    always @(negedge clk) begin
        if (!reset && decode_tvalid === 1'b1 && decode_tready && !stall) begin
            chk("stream_pc", decode_pc, exp_pc);
            chk("stream_ir", decode_ir, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_acc++;
        end
    end

    initial begin
        tick(); tick(); tick();
        #1;
        chk("rst_imem_en", {31'b0, imem_en}, 32'd0);
        chk("rst_tvalid", {31'b0, decode_tvalid}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);

        reset = 1'b0;
        #1;
        chk("first_en", {31'b0, imem_en}, 32'd1);
        chk("first_addr", imem_addr, 32'h100);
        tick(); #1;
        chk("addr_104", imem_addr, 32'h104);
        chk("tvalid_n1", {31'b0, decode_tvalid}, 32'd0);
        tick(); #1;
        chk("tvalid_n2", {31'b0, decode_tvalid}, 32'd1);
        chk("pc_n2", decode_pc, 32'h100);
        chk("addr_108", imem_addr, 32'h108);
        tick(); #1;
        chk("pc_n3", decode_pc, 32'h104);

        decode_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (imem_en) n_issue++;
            chk("bp_pc_stable", decode_pc, 32'h104);
            chk("bp_tvalid", {31'b0, decode_tvalid}, 32'd1);
            tick();
        end
        chk("bp_issue_bound", {31'b0, n_issue <= 2}, 32'd1);
        decode_tready = 1'b1;
        repeat (6) tick();

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_no_issue", {31'b0, imem_en}, 32'd0);
            chk("stall_tvalid", {31'b0, decode_tvalid}, 32'd1);
            chk("stall_pc", decode_pc, exp_pc);
            tick();
        end
        stall = 1'b0;
        repeat (5) tick();

        redirect_valid = 1'b1; redirect_addr = 32'h200;
        tick();
        redirect_valid = 1'b0;
        exp_pc = 32'h200;
        tick(); tick(); #1;
        chk("redir_tvalid", {31'b0, decode_tvalid}, 32'd1);
        chk("redir_pc", decode_pc, 32'h200);
        bubble = 1'b1;
        #1;
        chk("bubble_no_issue", {31'b0, imem_en}, 32'd0);
        tick();
        bubble = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("wait_tvalid", {31'b0, decode_tvalid}, 32'd0);
            chk("wait_no_issue", {31'b0, imem_en}, 32'd0);
            tick();
        end
        redirect_valid = 1'b1; redirect_addr = 32'h400;
        #1;
        chk("wait_tvalid_r", {31'b0, decode_tvalid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        exp_pc = 32'h400;
        #1;
        chk("r400_en", {31'b0, imem_en}, 32'd1);
        chk("r400_addr", imem_addr, 32'h400);
        tick(); tick(); #1;
        chk("r400_pc", decode_pc, 32'h400);
        chk("r400_tvalid", {31'b0, decode_tvalid}, 32'd1);
        repeat (3) tick();

        redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        exp_pc = 32'hFFFF_FFF8;
        #1;
        chk("wrap_a0", imem_addr, 32'hFFFF_FFF8);
        tick(); #1;
        chk("wrap_a1", imem_addr, 32'hFFFF_FFFC);
        tick(); #1;
        chk("wrap_a2", imem_addr, 32'h0000_0000);
        repeat (4) tick();

`ifdef FETCH_ALIGN_CHECK_EN
        redirect_valid = 1'b1; redirect_addr = 32'h402;
        tick();
        redirect_valid = 1'b0;
        exp_pc = 32'h404;
        #1;
        chk("mis_fault", {31'b0, fault}, 32'd1);
        chk("mis_no_issue", {31'b0, imem_en}, 32'd0);
        chk("mis_tvalid", {31'b0, decode_tvalid}, 32'd0);
        tick(); #1;
        chk("mis_fault_off", {31'b0, fault}, 32'd0);
        chk("mis_idle1", {31'b0, imem_en}, 32'd0);
        tick(); #1;
        chk("mis_idle2", {31'b0, imem_en}, 32'd0);
        redirect_valid = 1'b1; redirect_addr = 32'h404;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("al_en", {31'b0, imem_en}, 32'd1);
        chk("al_addr", imem_addr, 32'h404);
        tick(); tick(); #1;
        chk("al_pc", decode_pc, 32'h404);
`else
        redirect_valid = 1'b1; redirect_addr = 32'h402;
        tick();
        redirect_valid = 1'b0;
        exp_pc = 32'h400;
        #1;
        chk("nochk_fault", {31'b0, fault}, 32'd0);
        chk("nochk_addr", imem_addr, 32'h400);
        tick(); tick(); #1;
        chk("nochk_pc", decode_pc, 32'h400);
`endif
        repeat (3) tick();

        reset = 1'b1;
        tick();
        #1;
        chk("mid_rst_tvalid", {31'b0, decode_tvalid}, 32'd0);
        chk("mid_rst_en", {31'b0, imem_en}, 32'd0);
        reset = 1'b0;
        exp_pc = 32'h100;
        #1;
        chk("mid_rst_addr", imem_addr, 32'h100);
        tick(); tick(); #1;
        chk("mid_rst_pc", decode_pc, 32'h100);
        repeat (4) tick();
        chk("accepted_any", {31'b0, n_acc > 20}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
